uart_rx_buffer: RTL and testbench

//   Receive-side buffer placed directly after the UART receiver. Captures each
//   9-bit word on the receiver's done pulse into a show-ahead FIFO, which the

---
 rtl/uart_rx_buffer.sv | 140 ++++++++++++++
 tb/tb_uart_rx_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffer
// Description : Receive-side buffer behind the UART receiver. Each word
//               presented with rx_done is captured into a show-ahead FIFO
//               that the command decoder drains over valid/ready. Receiver
//               framing errors (rising edges) are counted in a saturating
//               counter, and dropped words set a sticky overflow flag. Both
//               status items are cleared by clear_status.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               rx_data, rx_done    - received word and its one-cycle strobe
//               rx_framing_error    - receiver framing-error level
//               rd_data, rd_valid   - head-of-FIFO word, FIFO non-empty
//               rd_ready            - consumer takes rd_data this cycle
//               count               - occupancy, 0..DEPTH
//               overflow            - sticky: word dropped on full FIFO
//               error_count         - saturating framing-error event count
//               clear_status        - clears overflow and error_count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8,
   parameter int ERR_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         rx_data,
   input  logic                     rx_done,
   input  logic                     rx_framing_error,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [ERR_W-1:0]         error_count,
   input  logic                     clear_status
);

   localparam int                 PTR_W      = $clog2(DEPTH);
   localparam int                 CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   ONE_COUNT  = CNT_W'(1);
   localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_next;
   logic             fe_prev;

   logic             pop;
   logic             push;
   logic             drop;
   logic             full;
   logic             fe_edge;
   logic [WIDTH-1:0] head_next;

   // Valid is derived from the registered occupancy, so no rx_* input can
   // reach any output combinationally.
   assign rd_valid    = (count != '0);
   assign full        = (count == FULL_COUNT);
   assign pop         = rd_valid && rd_ready;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a word.
   assign push        = rx_done && (!full || pop);
   assign drop        = rx_done && full && !pop;
   assign rd_ptr_next = rd_ptr + PTR_W'(1);
   assign fe_edge     = rx_framing_error && !fe_prev;

   // Show-ahead head register: the value rd_data must show after this edge.
   // When the FIFO holds a single word that is popped while a new word
   // arrives, the new word is not in storage yet, so bypass it from rx_data.
   always_comb begin
      head_next = rd_data;
      if (push && (count == '0)) begin
         head_next = rx_data;
      end else if (pop) begin
         if (count == ONE_COUNT) begin
            if (push) begin
               head_next = rx_data;
            end
         end else begin
            head_next = mem[rd_ptr_next];
         end
      end
   end

   // Storage carries no reset; pointers and count define which entries are live.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         rd_data <= head_next;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr_next;
         end
         case ({push, pop})
            2'b10:   count <= count + ONE_COUNT;
            2'b01:   count <= count - ONE_COUNT;
            default: count <= count;
         endcase
      end
   end

   // Status: a same-cycle event wins over clear_status, so nothing is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         fe_prev     <= 1'b0;
         overflow    <= 1'b0;
         error_count <= '0;
      end else begin
         fe_prev <= rx_framing_error;
         if (clear_status) begin
            overflow    <= drop;
            error_count <= fe_edge ? ERR_W'(1) : '0;
         end else begin
            if (drop) begin
               overflow <= 1'b1;
            end
            if (fe_edge && (error_count != ERR_MAX)) begin
               error_count <= error_count + ERR_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Self-checking bench for uart_rx_buffer. A table of directed
//               single-cycle vectors covers the basic handshake and status
//               behaviour; hand-written sequences cover overflow, full-FIFO
//               push/pop, pointer wrap, counter saturation and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffer;

   logic       clock = 1'b0;
   logic       reset;
   logic [8:0] rx_data;
   logic       rx_done;
   logic       rx_framing_error;
   logic [8:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [3:0] count;
   logic       overflow;
   logic [7:0] error_count;
   logic       clear_status;

   int total = 0;
   int bad   = 0;

   logic [8:0] model_q[$];
   logic       exp_ovf;

   uart_rx_buffer #(.WIDTH(9), .DEPTH(8), .ERR_W(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .rx_data          (rx_data),
      .rx_done          (rx_done),
      .rx_framing_error (rx_framing_error),
      .rd_data          (rd_data),
      .rd_valid         (rd_valid),
      .rd_ready         (rd_ready),
      .count            (count),
      .overflow         (overflow),
      .error_count      (error_count),
      .clear_status     (clear_status)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       done;
      logic [8:0] data;
      logic       ready;
      logic       fe;
      logic       clr;
      logic       exp_valid;
      logic [8:0] exp_data;
      logic [3:0] exp_count;
      logic       exp_ovf;
      logic [7:0] exp_err;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic done, input logic [8:0] data, input logic ready,
                      input logic fe, input logic clr);
      rx_done          = done;
      rx_data          = data;
      rd_ready         = ready;
      rx_framing_error = fe;
      clear_status     = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      model_q.delete();
      exp_ovf = 1'b0;
   endtask

   // One FIFO cycle checked against a queue reference model.
   task automatic mstep(input string tag, input logic done, input logic [8:0] data,
                        input logic ready);
      logic m_pop;
      logic m_push;
      m_pop  = (model_q.size() > 0) && ready;
      m_push = done && ((model_q.size() < 8) || m_pop);
      cyc(done, data, ready, 1'b0, 1'b0);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(data);
      if (done && !m_push) exp_ovf = 1'b1;
      chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
      chk({tag, ".valid"}, 32'(rd_valid), 32'(model_q.size() > 0));
      if (model_q.size() > 0) chk({tag, ".data"}, 32'(rd_data), 32'(model_q[0]));
      chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
   endtask

   initial begin
      reset = 1'b1;
      rx_done = 1'b0; rx_data = '0; rd_ready = 1'b0;
      rx_framing_error = 1'b0; clear_status = 1'b0;
      exp_ovf = 1'b0;

      //          done data    rdy fe clr | valid data    cnt ovf err
      vecs[0]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 9'h1A5, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5, 4'd1, 1'b0, 8'd0};
      vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5, 4'd1, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h1A5, 4'd0, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h1A5, 4'd0, 1'b0, 8'd0};
      vecs[5]  = '{1'b1, 9'h011, 1'b0, 1'b0, 1'b0, 1'b1, 9'h011, 4'd1, 1'b0, 8'd0};
      vecs[6]  = '{1'b1, 9'h022, 1'b1, 1'b0, 1'b0, 1'b1, 9'h022, 4'd1, 1'b0, 8'd0};
      vecs[7]  = '{1'b1, 9'h033, 1'b0, 1'b0, 1'b0, 1'b1, 9'h022, 4'd2, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 9'h022, 4'd2, 1'b0, 8'd1};
      vecs[9]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 9'h022, 4'd2, 1'b0, 8'd1};
      vecs[10] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h022, 4'd2, 1'b0, 8'd0};
      vecs[11] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 9'h022, 4'd2, 1'b0, 8'd1};
      vecs[12] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 9'h033, 4'd1, 1'b0, 8'd1};
      vecs[13] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h033, 4'd0, 1'b0, 8'd1};
      vecs[14] = '{1'b1, 9'h044, 1'b0, 1'b1, 1'b0, 1'b1, 9'h044, 4'd1, 1'b0, 8'd2};
      vecs[15] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 9'h044, 4'd0, 1'b0, 8'd2};

      // ---- Table-driven vectors ----
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cyc(vecs[i].done, vecs[i].data, vecs[i].ready, vecs[i].fe, vecs[i].clr);
         chk($sformatf("vec%0d.valid", i), 32'(rd_valid),    32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d.data", i),  32'(rd_data),     32'(vecs[i].exp_data));
         chk($sformatf("vec%0d.count", i), 32'(count),       32'(vecs[i].exp_count));
         chk($sformatf("vec%0d.ovf", i),   32'(overflow),    32'(vecs[i].exp_ovf));
         chk($sformatf("vec%0d.err", i),   32'(error_count), 32'(vecs[i].exp_err));
      end

      // ---- Overflow: 8 words then a 9th that must be dropped ----
      do_reset();
      for (int i = 1; i <= 8; i++) mstep("fill", 1'b1, 9'(i), 1'b0);
      mstep("ovf_drop", 1'b1, 9'h0FF, 1'b0);
      chk("ovf_count8", 32'(count), 32'd8);
      chk("ovf_set", 32'(overflow), 32'd1);
      // Clear with no event: status clears, FIFO untouched
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
      exp_ovf = 1'b0;
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_err", 32'(error_count), 32'd0);
      chk("clr_count", 32'(count), 32'd8);
      // Clear coincident with a drop: overflow must stay set
      cyc(1'b1, 9'h0EE, 1'b0, 1'b0, 1'b1);
      exp_ovf = 1'b1;
      chk("clr_drop_ovf", 32'(overflow), 32'd1);
      chk("clr_drop_count", 32'(count), 32'd8);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain%0d", i), 32'(rd_data), 32'(i));
         mstep("drain", 1'b0, 9'h000, 1'b1);
      end
      chk("drain_empty", 32'(rd_valid), 32'd0);

      // ---- Full FIFO: push together with pop is accepted ----
      do_reset();
      for (int i = 1; i <= 8; i++) mstep("fill2", 1'b1, 9'(9'h010 + i), 1'b0);
      mstep("full_pp", 1'b1, 9'h155, 1'b1);
      chk("full_pp_count", 32'(count), 32'd8);
      chk("full_pp_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) mstep("drain2", 1'b0, 9'h000, 1'b1);
      chk("last_155", 32'(rd_data), 32'h155);
      // Mixed push/pop traffic across pointer wrap
      for (int i = 0; i < 20; i++)
         mstep($sformatf("wrap%0d", i), 1'b1, 9'(9'h080 + i), 1'((i % 3) != 0));
      while (model_q.size() > 0) mstep("drain3", 1'b0, 9'h000, 1'b1);

      // ---- Framing-error counting and saturation ----
      do_reset();
      for (int i = 0; i < 50; i++) cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
      chk("fe_held", 32'(error_count), 32'd1);
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
         cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      end
      chk("fe_four", 32'(error_count), 32'd4);
      for (int i = 0; i < 250; i++) begin
         cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
         cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      end
      chk("fe_254", 32'(error_count), 32'd254);
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
         cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
      end
      chk("fe_sat", 32'(error_count), 32'd255);
      // Clear coincident with a new edge leaves a count of one
      cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
      chk("clr_edge", 32'(error_count), 32'd1);
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
      chk("clr_plain", 32'(error_count), 32'd0);

      // ---- Reset mid-drain discards contents and in-flight word ----
      do_reset();
      for (int i = 0; i < 5; i++) mstep("load5", 1'b1, 9'(9'h120 + i), 1'b0);
      cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
      chk("pre_rst_err", 32'(error_count), 32'd1);
      mstep("mid_drain", 1'b0, 9'h000, 1'b1);
      reset = 1'b1;
      cyc(1'b1, 9'h1DD, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      model_q.delete();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_err", 32'(error_count), 32'd0);
      mstep("post_rst", 1'b1, 9'h1EE, 1'b0);
      chk("post_rst_head", 32'(rd_data), 32'h1EE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
